// File: rtl/word_unpacker.sv
// word_unpacker: splits 136-bit packed chunks into 34-bit or 68-bit words on request.
// An 8-unit buffer lets a long word straddle two consecutive chunks.
module word_unpacker #(
    parameter int unsigned I_WIDTH1    = 68,
    parameter int unsigned I_WIDTH2    = 34,
    parameter int unsigned TOTAL_WIDTH = 136
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    input  logic [TOTAL_WIDTH-1:0] i_reg_array,
    output logic                   o_in_ready,
    input  logic                   i_rd_en,
    input  logic                   i_rd_len,
    input  logic                   i_flush,
    output logic [I_WIDTH1-1:0]    o_word,
    output logic                   o_valid,
    output logic                   o_underflow,
    output logic [3:0]             o_count
);

    localparam int unsigned UNITS       = 8;
    localparam int unsigned CHUNK_UNITS = 4;

    logic [I_WIDTH2-1:0] buf_q   [UNITS];
    logic [I_WIDTH2-1:0] buf_n   [UNITS];
    logic [I_WIDTH2-1:0] chunk_u [CHUNK_UNITS];

    logic [3:0]          cnt_q;
    logic [3:0]          cnt_n;
    logic [3:0]          cnt_rd;
    logic [3:0]          need;
    logic                rd_ok;
    logic                wr_ok;
    logic [I_WIDTH1-1:0] word_n;

    // Read/shift first, then append the accepted chunk behind what remains.
    always_comb begin
        need   = i_rd_len ? 4'd2 : 4'd1;
        rd_ok  = i_rd_en && (cnt_q >= need);
        wr_ok  = i_in_valid && o_in_ready && !i_flush;
        cnt_rd = rd_ok ? 4'(cnt_q - need) : cnt_q;
        word_n = i_rd_len ? {buf_q[1], buf_q[0]}
                          : {(I_WIDTH1 - I_WIDTH2)'(0), buf_q[0]};

        for (int unsigned j = 0; j < CHUNK_UNITS; j++) begin
            chunk_u[j] = i_reg_array[j*I_WIDTH2 +: I_WIDTH2];
        end

        for (int unsigned k = 0; k < UNITS; k++) begin
            buf_n[k] = buf_q[k];
        end

        // Top slots left stale after a shift are above cnt and never read.
        if (rd_ok) begin
            if (i_rd_len) begin
                for (int unsigned k = 0; k < UNITS - 2; k++) begin
                    buf_n[k] = buf_q[k+2];
                end
            end else begin
                for (int unsigned k = 0; k < UNITS - 1; k++) begin
                    buf_n[k] = buf_q[k+1];
                end
            end
        end

        if (wr_ok) begin
            for (int unsigned k = 0; k < UNITS; k++) begin
                if ((4'(k) >= cnt_rd) && (4'(k) < 4'(cnt_rd + 4'd4))) begin
                    buf_n[k] = chunk_u[2'(4'(k) - cnt_rd)];
                end
            end
        end

        if (i_flush) begin
            cnt_n = 4'd0;
        end else if (wr_ok) begin
            cnt_n = 4'(cnt_rd + 4'd4);
        end else begin
            cnt_n = cnt_rd;
        end
    end

    // Data storage; contents above cnt are don't-care so no reset is needed.
    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < UNITS; k++) begin
            buf_q[k] <= buf_n[k];
        end
    end

    // Count and registered outputs; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q       <= 4'd0;
            o_in_ready  <= 1'b1;
            o_valid     <= 1'b0;
            o_underflow <= 1'b0;
            o_word      <= '0;
        end else begin
            cnt_q       <= cnt_n;
            o_in_ready  <= (cnt_n <= 4'd4);
            o_valid     <= rd_ok;
            o_underflow <= i_rd_en && !rd_ok;
            if (rd_ok) begin
                o_word <= word_n;
            end
        end
    end

    assign o_count = cnt_q;

endmodule
